// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - UART 8N1 transmitter with a small byte FIFO
//
// Purpose:
//   Queues bytes written through a one-cycle strobe and serialises them onto
//   tx as 8N1 frames: one start bit (0), eight data bits LSB first, one stop
//   bit (1). Each bit lasts DIV_NUM clocks. Queued bytes go out back to back
//   with no idle gap between frames.
//
// Parameters:
//   DIV_NUM  clocks per bit (>= 2)
//   WIDTH    bit-timer width, 2**WIDTH > DIV_NUM
//   FIFO_AW  FIFO address width, depth = 2**FIFO_AW bytes
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   data_en   in   write strobe, data_in sampled when high
//   data_in   in   byte to send
//   tx        out  serial line, idles high (registered)
//   busy      out  FSM not idle or FIFO non-empty (registered)
//   full      out  FIFO holds DEPTH bytes (registered)
//   overflow  out  one-cycle pulse when a write was dropped (registered)

module uart_transmit #(
    parameter int DIV_NUM = 5208,
    parameter int WIDTH   = 13,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_en,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int                 DEPTH    = 2 ** FIFO_AW;
    localparam logic [WIDTH-1:0]   BIT_LAST = WIDTH'(DIV_NUM - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     timer_q, timer_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 full_q, full_d;
    logic                 ovf_q, ovf_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic [7:0]           mem_q [DEPTH];

    logic                 wr_en;
    logic                 pop;
    logic                 fifo_empty;
    logic                 bit_done;
    logic [7:0]           head;

    assign fifo_empty = (count_q == '0);
    assign wr_en      = data_en && !full_q;
    assign bit_done   = (timer_q == BIT_LAST);
    assign head       = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // FSM: next state, bit timer, shift register and line value
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        // The timer free-runs 0..DIV_NUM-1 in every non-idle state; each
        // wrap marks the end of one bit period.
        if (state_q != S_IDLE) begin
            timer_d = bit_done ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                timer_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bit_done) begin
                    tx_d    = shift_q[0];
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (bit_done) begin
                    if (idx_q != 3'd7) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 1'b1;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when more bytes
                    // are queued so frames are contiguous on the line.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping and registered status flags
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Status flags are computed from next-state values so they line up
        // with the registered FIFO and FSM state after the same edge.
        busy_d = (state_d != S_IDLE) || (count_d != '0);
        full_d = (count_d == CNT_FULL);
        ovf_d  = data_en && full_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_transmit.sv
// tb/tb_uart_transmit.sv - directed self-checking bench for uart_transmit

module tb_uart_transmit;

    localparam int DIV = 8;

    logic       clk;
    logic       rst_n;
    logic       data_en;
    logic [7:0] data_in;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int full_cnt = 0;

    logic [7:0] wbuf [8];

    uart_transmit #(
        .DIV_NUM (DIV),
        .WIDTH   (4),
        .FIFO_AW (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_en  (data_en),
        .data_in  (data_in),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (full === 1'b1) full_cnt <= full_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered just after a negedge; drives one byte per clock edge.
    task automatic write_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            data_en = 1'b1;
            data_in = wbuf[i];
            @(negedge clk);
        end
        data_en = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then checks every sample of the
    // 10-bit frame against the expected waveform and decodes the byte.
    task automatic recv_frame(input string tag, input logic [7:0] exp,
                              input int maxwait, output int waited);
        logic [9:0] want;
        logic [7:0] got;
        logic       shape_ok;
        logic       busy_ok;
        want   = {1'b1, exp, 1'b0};
        waited = 0;
        while (tx !== 1'b0 && waited < maxwait) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            check_eq($sformatf("%s_start_timeout", tag), 32'(tx), 32'(0));
            return;
        end
        shape_ok = 1'b1;
        busy_ok  = 1'b1;
        got      = 8'h00;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < DIV; c++) begin
                if (tx !== want[b]) shape_ok = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (c == DIV / 2 && b >= 1 && b <= 8) got[b-1] = tx;
                @(negedge clk);
            end
        end
        check_eq($sformatf("%s_shape", tag), 32'(shape_ok), 32'(1));
        check_eq($sformatf("%s_byte", tag), 32'(got), 32'(exp));
        check_eq($sformatf("%s_busy", tag), 32'(busy_ok), 32'(1));
    endtask

    task automatic expect_idle(input string tag, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        check_eq(tag, 32'(ok), 32'(1));
    endtask

    initial begin
        int         w;
        int         w1;
        int         gaps;
        int         f0;
        logic [6:0] fv;
        logic [6:0] ov;

        rst_n   = 1'b0;
        data_en = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(tx), 32'(1));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_full", 32'(full), 32'(0));
        check_eq("rst_ovf", 32'(overflow), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        expect_idle("idle_after_rst", 5);

        // 1: single 0x55, latency and busy envelope
        wbuf[0] = 8'h55;
        fork
            begin
                write_bytes(1);
                check_eq("t1_busy_rise", 32'(busy), 32'(1));
                check_eq("t1_tx_still_high", 32'(tx), 32'(1));
            end
            recv_frame("t1", 8'h55, 5, w);
        join
        check_eq("t1_latency", 32'(w), 32'(2));
        check_eq("t1_busy_fall", 32'(busy), 32'(0));
        expect_idle("t1_idle", 10);

        // 2: 0xA3 -> LSB first 1,1,0,0,0,1,0,1
        wbuf[0] = 8'hA3;
        fork
            write_bytes(1);
            recv_frame("t2", 8'hA3, 5, w);
        join
        expect_idle("t2_idle", 10);

        // 3: four consecutive writes -> contiguous frames, never full
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h04;
        f0 = full_cnt;
        gaps = 0;
        fork
            write_bytes(4);
            begin
                recv_frame("t3_f0", 8'h01, 5, w1);
                for (int k = 1; k < 4; k++) begin
                    recv_frame($sformatf("t3_f%0d", k), 8'(k + 1), 3, w);
                    gaps += w;
                end
            end
        join
        check_eq("t3_first_latency", 32'(w1), 32'(2));
        check_eq("t3_no_gap", 32'(gaps), 32'(0));
        check_eq("t3_never_full", 32'(full_cnt - f0), 32'(0));
        expect_idle("t3_idle", 10);

        // 4: six writes -> full after 5th, 6th dropped, five frames
        fv = '0;
        ov = '0;
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    data_en = (i < 6);
                    data_in = 8'((i + 1) * 17);
                    @(negedge clk);
                    fv[i] = full;
                    ov[i] = overflow;
                end
                data_en = 1'b0;
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    recv_frame($sformatf("t4_f%0d", k), 8'((k + 1) * 17), 5, w);
                end
            end
        join
        check_eq("t4_full_trace", 32'(fv), 32'(7'b1110000));
        check_eq("t4_ovf_trace", 32'(ov), 32'(7'b0100000));
        expect_idle("t4_no_sixth", 30);

        // 5: async reset during data bit 3 discards frame and queue
        data_en = 1'b1;
        data_in = 8'hF0;
        @(negedge clk);
        data_in = 8'h3C;
        @(negedge clk);
        data_en = 1'b0;
        repeat (34) @(negedge clk);
        check_eq("t5_pre_tx", 32'(tx), 32'(0));
        check_eq("t5_pre_busy", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_tx", 32'(tx), 32'(1));
        check_eq("t5_async_busy", 32'(busy), 32'(0));
        check_eq("t5_async_full", 32'(full), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_idle("t5_quiet", 100);
        wbuf[0] = 8'h5A;
        fork
            write_bytes(1);
            recv_frame("t5_after", 8'h5A, 5, w);
        join
        check_eq("t5_latency", 32'(w), 32'(2));
        expect_idle("t5_idle", 10);

        // 6: write on the very edge STOP ends with an empty FIFO
        fork
            begin
                data_en = 1'b1;
                data_in = 8'hC6;
                @(negedge clk);
                data_en = 1'b0;
                repeat (10 * DIV) @(negedge clk);
                data_en = 1'b1;
                data_in = 8'h39;
                @(negedge clk);
                data_en = 1'b0;
            end
            begin
                recv_frame("t6_a", 8'hC6, 5, w1);
                check_eq("t6_busy_hold", 32'(busy), 32'(1));
                check_eq("t6_idle_tx", 32'(tx), 32'(1));
                recv_frame("t6_b", 8'h39, 5, w);
            end
        join
        check_eq("t6_restart_gap", 32'(w), 32'(1));
        check_eq("t6_busy_end", 32'(busy), 32'(0));
        expect_idle("t6_idle", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
